// File: rtl/seg_pipe_adder_pkg.sv
// Shared configuration helpers for the segment-pipelined adder/subtractor.
package seg_pipe_adder_pkg;

   function automatic int stages_f(input int width, input int seg);
      return width / seg;
   endfunction

   // Legal when the segment fits the operand and tiles it exactly.
   function automatic bit cfg_ok_f(input int width, input int seg);
      return (seg >= 1) && (seg <= width) && ((width % seg) == 0);
   endfunction

endpackage

// File: rtl/seg_rca.sv
// Combinational SEG-bit ripple-carry segment built from full adders.
module seg_rca #(
   parameter int SEG = 4
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           ci,
   output logic [SEG-1:0] s,
   output logic           co,
   output logic           c_msb
);

   logic [SEG:0] w_c;

   // Full-adder chain; w_c[i] is the carry into bit i.
   always_comb begin
      w_c    = '0;
      s      = '0;
      w_c[0] = ci;
      for (int i = 0; i < SEG; i++) begin
         s[i]     = a[i] ^ b[i] ^ w_c[i];
         w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
      end
   end

   assign co    = w_c[SEG];
   assign c_msb = w_c[SEG-1];

endmodule

// File: rtl/seg_pipe_adder.sv
// Segment-pipelined adder/subtractor: one SEG-bit ripple segment per stage,
// valid/ready handshake with a single global advance for back-pressure.
module seg_pipe_adder
   import seg_pipe_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = stages_f(WIDTH, SEG);

   if (!cfg_ok_f(WIDTH, SEG)) begin : g_cfg_err
      $error("seg_pipe_adder: WIDTH must be a positive multiple of SEG");
   end

   logic [WIDTH-1:0] w_a_q [STAGES];
   logic [WIDTH-1:0] w_b_q [STAGES];
   logic [WIDTH-1:0] w_s_q [STAGES];
   logic             w_c_q [STAGES];
   logic             w_v_q [STAGES];
   logic             w_co  [STAGES];
   logic             w_cm  [STAGES];
   logic             w_adv;
   logic             r_ovf;

   // All stages move together; a stalled output freezes the whole pipe.
   assign w_adv    = !w_v_q[STAGES-1] | out_ready;
   assign in_ready = w_adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] w_a_in, w_b_in, w_s_in, w_s_nxt;
      logic             w_c_in, w_v_in;
      logic [SEG-1:0]   w_seg_s;
      logic             w_seg_co, w_seg_cm;
      logic [WIDTH-1:0] r_a, r_b, r_s;
      logic             r_c, r_v;

      if (k == 0) begin : g_first
         assign w_a_in = a;
         assign w_b_in = sub ? ~b : b;
         assign w_s_in = '0;
         assign w_c_in = sub ? 1'b1 : cin;
         assign w_v_in = in_valid;
      end else begin : g_next
         assign w_a_in = w_a_q[k-1];
         assign w_b_in = w_b_q[k-1];
         assign w_s_in = w_s_q[k-1];
         assign w_c_in = w_c_q[k-1];
         assign w_v_in = w_v_q[k-1];
      end

      seg_rca #(.SEG(SEG)) u_rca (
         .a     (w_a_in[k*SEG +: SEG]),
         .b     (w_b_in[k*SEG +: SEG]),
         .ci    (w_c_in),
         .s     (w_seg_s),
         .co    (w_seg_co),
         .c_msb (w_seg_cm)
      );

      // Splice this stage's segment into the partial sum.
      always_comb begin
         w_s_nxt                 = w_s_in;
         w_s_nxt[k*SEG +: SEG]   = w_seg_s;
      end

      // Stage register: partial sum, pending operands, carry and valid.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_v <= 1'b0;
            r_c <= 1'b0;
            r_a <= '0;
            r_b <= '0;
            r_s <= '0;
         end else if (w_adv) begin
            r_v <= w_v_in;
            r_c <= w_seg_co;
            r_a <= w_a_in;
            r_b <= w_b_in;
            r_s <= w_s_nxt;
         end
      end

      assign w_a_q[k] = r_a;
      assign w_b_q[k] = r_b;
      assign w_s_q[k] = r_s;
      assign w_c_q[k] = r_c;
      assign w_v_q[k] = r_v;
      assign w_co[k]  = w_seg_co;
      assign w_cm[k]  = w_seg_cm;
   end

   // Overflow is formed in the last stage and registered alongside its carry.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_adv) begin
         r_ovf <= w_cm[STAGES-1] ^ w_co[STAGES-1];
      end
   end

   assign out_valid = w_v_q[STAGES-1];
   assign sum       = w_s_q[STAGES-1];
   assign cout      = w_c_q[STAGES-1];
   assign ovf       = r_ovf;

endmodule

// File: doc/seg_pipe_adder.md
Name: seg_pipe_adder

Overview:
- Parametrised, segment-pipelined ripple-carry adder/subtractor. Successor to the team's fixed 16-bit four-segment RCA.
- Operand width and segment width are generic. One pipeline register is placed between segments, so the carry ripples one segment per clock.
- Adds subtract mode, signed-overflow detection and valid/ready handshakes with full back-pressure.
- Sits between operand-producing datapath logic and any consumer that can tolerate latency in exchange for clock rate.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of SEG.
- SEG, 4, bits added per pipeline stage (segment width); 1 <= SEG <= WIDTH.
- STAGES, WIDTH/SEG, derived (localparam), pipeline depth; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts the beat this cycle
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- cin  input  1  carry in; used in add mode only
- sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1, cin ignored)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  result
- cout  output  1  carry out of the MSB; in sub mode 1 means no borrow
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); no asynchronous reset anywhere.
- Reset: all stage valid bits clear. The following are 0 the cycle after rst is sampled high: out_valid, sum, cout, ovf. in_ready is 1 after reset.
- Global advance: adv = !out_valid | out_ready. in_ready = adv, so it is combinational from out_ready. Every stage register loads only when adv = 1; otherwise all stages hold.
- Accept: a beat is taken when in_valid & in_ready. Beats are never dropped or duplicated.
- Bubbles: if in_valid = 0 while adv = 1, a bubble (valid = 0) enters stage 0.
- Stage k (0..STAGES-1):
  - adds segment k of A and of B' (B' = sub ? ~b : b) with the carry from stage k-1.
  - stage 0 carry-in is sub ? 1 : cin.
  - registers: the finished low segments, the remaining unprocessed high segments of A and B', its carry out, and its valid bit.
  - the final stage also registers the carry into the MSB, for ovf.
- Latency: exactly STAGES cycles from accept to out_valid, with no stalls. Throughput is 1 result per cycle.
- Output hold: while out_valid & !out_ready, sum/cout/ovf/out_valid hold stable and in_ready = 0.
- Simultaneous events:
  - out_ready and in_valid in the same cycle with a full pipe: the result retires and the new beat is accepted in that same cycle.
  - rst in the same cycle as a handshake: rst wins; the accepted beat is discarded.
- Reset mid-operation: all in-flight beats are discarded. No partial result is ever presented.
- Arithmetic: modulo 2^WIDTH.
  - cout is the true carry out of bit WIDTH-1.
  - ovf is valid in both modes regardless of whether the operands are signed; the consumer decides whether to use it.
- Degenerate case SEG = WIDTH: STAGES = 1; behaves as a single registered adder with the same handshake.
- Values on the data outputs while out_valid = 0 are don't-care for the checker, but must not be X after reset.

Decomposition:
- Package seg_pipe_adder_pkg holds:
  - localparam function stages_f(WIDTH, SEG);
  - an elaboration-time assertion helper checking WIDTH % SEG == 0.
- Sub-module seg_rca: combinational SEG-bit ripple-carry segment built from full adders.
  - Ports: a, b, ci; outputs s, co, and c_msb (the carry into its top bit).
  - Instantiated once per stage with a generate loop; the final stage's c_msb drives ovf.

Test Plan:
All scenarios use WIDTH=16, SEG=4, so STAGES=4.
- Add wrap: a=0xFFFF, b=0x0001, cin=0, sub=0 -> 4 cycles later sum=0x0000, cout=1, ovf=0.
- Signed overflow add: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x1234, b=0x0000, cin=1 -> sum=0x1235, cout=0, ovf=0.
- Subtract: a=0x8000, b=0x0001, sub=1, cin=1 (ignored) -> sum=0x7FFF, cout=1, ovf=1. Then a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
- Streaming: 8 back-to-back beats with out_ready=1 -> first out_valid at cycle 4, then 8 consecutive results in order; in_ready stays 1 throughout.
- Back-pressure: fill the pipe, then hold out_ready=0 for 3 cycles -> in_ready=0, output held bit-stable, no beat lost. On release, results resume in order, one per cycle.
- Reset mid-flight: accept 3 beats, assert rst for 1 cycle -> next cycle out_valid=0, sum=0, cout=0, ovf=0, in_ready=1. No stale result appears for the next 4 cycles.
